// File: rtl/exec_stage_if.sv
// Handshake bus between decode, the execute stage and writeback.
// The slave modport is the execute stage; the master modport is its environment.
interface exec_stage_if #(
   parameter int WIDTH = 16,
   parameter int IMM_W = 6,
   parameter int RA_W  = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [RA_W-1:0]  rd;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic [IMM_W-1:0] imm;
   logic             out_valid;
   logic             out_ready;
   logic [RA_W-1:0]  out_rd;
   logic [WIDTH-1:0] out_result;
   logic             out_we;
   logic             busy;

   modport slave (
      input  in_valid, op, rd, rs_val, rt_val, imm, out_ready,
      output in_ready, out_valid, out_rd, out_result, out_we, busy
   );

   modport master (
      output in_valid, op, rd, rs_val, rt_val, imm, out_ready,
      input  in_ready, out_valid, out_rd, out_result, out_we, busy
   );
endinterface

// File: rtl/exec_stage.sv
// Registered execute stage: single-cycle ALU ops, bit-serial shifts, and a
// result held at a valid/ready output until writeback takes it.
module exec_stage #(
   parameter int WIDTH = 16,
   parameter int IMM_W = 6,
   parameter int RA_W  = 3
) (
   input logic         clk,
   input logic         reset,
   exec_stage_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_SLT  = 4'd4;
   localparam logic [3:0] OP_SLTI = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;

   state_t           state_r;
   logic [WIDTH-1:0] shreg_r;
   logic [3:0]       cnt_r;
   logic             shift_left_r;

   logic             accept_s;
   logic             xfer_out_s;
   logic [WIDTH-1:0] imm_ext_s;
   logic [WIDTH-1:0] alu_s;
   logic [WIDTH-1:0] shifted_s;
   logic [3:0]       amt_s;
   logic             is_shift_s;
   logic             we_s;

   assign bus.in_ready = (state_r == IDLE) || ((state_r == HOLD) && bus.out_ready);
   assign bus.busy     = (state_r != IDLE);
   assign accept_s     = bus.in_valid && bus.in_ready;
   assign xfer_out_s   = bus.out_valid && bus.out_ready;
   assign imm_ext_s    = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
   assign amt_s        = bus.rt_val[3:0];
   assign is_shift_s   = (bus.op == OP_SLL) || (bus.op == OP_SRL);
   assign we_s         = (bus.op <= OP_SRL);

   // Result of the instruction currently offered; shifts here only cover amount 0.
   always_comb begin
      alu_s = {WIDTH{1'b0}};
      case (bus.op)
         OP_ADD:  alu_s = bus.rs_val + bus.rt_val;
         OP_SUB:  alu_s = bus.rs_val - bus.rt_val;
         OP_AND:  alu_s = bus.rs_val & bus.rt_val;
         OP_OR:   alu_s = bus.rs_val | bus.rt_val;
         OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, (bus.rs_val < bus.rt_val)};
         OP_SLTI: alu_s = {{(WIDTH-1){1'b0}}, (bus.rs_val < imm_ext_s)};
         OP_ADDI: alu_s = bus.rs_val + imm_ext_s;
         OP_SLL:  alu_s = bus.rs_val << amt_s;
         OP_SRL:  alu_s = bus.rs_val >> amt_s;
         default: alu_s = {WIDTH{1'b0}};
      endcase
   end

   // One-bit step of the serial shifter.
   always_comb begin
      if (shift_left_r) begin
         shifted_s = {shreg_r[WIDTH-2:0], 1'b0};
      end else begin
         shifted_s = {1'b0, shreg_r[WIDTH-1:1]};
      end
   end

   // Stage FSM and registered result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= IDLE;
         shreg_r        <= {WIDTH{1'b0}};
         cnt_r          <= 4'd0;
         shift_left_r   <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.out_we     <= 1'b0;
         bus.out_rd     <= {RA_W{1'b0}};
         bus.out_result <= {WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE, HOLD: begin
               // A HOLD accept implies out_ready, so the old result leaves on this edge.
               if (accept_s) begin
                  bus.out_rd <= bus.rd;
                  bus.out_we <= we_s;
                  if (is_shift_s && (amt_s != 4'd0)) begin
                     shreg_r       <= bus.rs_val;
                     cnt_r         <= amt_s;
                     shift_left_r  <= (bus.op == OP_SLL);
                     bus.out_valid <= 1'b0;
                     state_r       <= SHIFT;
                  end else begin
                     bus.out_result <= alu_s;
                     bus.out_valid  <= 1'b1;
                     state_r        <= HOLD;
                  end
               end else if (xfer_out_s) begin
                  bus.out_valid <= 1'b0;
                  state_r       <= IDLE;
               end else begin
                  state_r <= state_r;
               end
            end
            SHIFT: begin
               shreg_r <= shifted_s;
               cnt_r   <= cnt_r - 4'd1;
               if (cnt_r == 4'd1) begin
                  bus.out_result <= shifted_s;
                  bus.out_valid  <= 1'b1;
                  state_r        <= HOLD;
               end else begin
                  state_r <= SHIFT;
               end
            end
            default: begin
               bus.out_valid <= 1'b0;
               state_r       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: hand-computed results, handshake timing,
// shift latency, backpressure and mid-shift reset.
module tb_exec_stage;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   exec_stage_if #(.WIDTH(16), .IMM_W(6), .RA_W(3)) bus ();

   exec_stage #(.WIDTH(16), .IMM_W(6), .RA_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [2:0] rd,
                        input logic [15:0] rs, input logic [15:0] rt, input logic [5:0] imm);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.rd       = rd;
      bus.rs_val   = rs;
      bus.rt_val   = rt;
      bus.imm      = imm;
   endtask

   task automatic idle_in();
      bus.in_valid = 1'b0;
      bus.op       = 4'hx;
      bus.rs_val   = 16'hxxxx;
      bus.rt_val   = 16'hxxxx;
   endtask

   initial begin
      int n;
      logic [15:0] add_exp [3];
      errors = 0;
      checks = 0;
      add_exp[0] = 16'd3;
      add_exp[1] = 16'd0;
      add_exp[2] = 16'd15;

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = 4'd0;
      bus.rd        = 3'd0;
      bus.rs_val    = 16'd0;
      bus.rt_val    = 16'd0;
      bus.imm       = 6'd0;
      bus.out_ready = 1'b0;
      step();
      step();
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_we", 32'(bus.out_we), 32'd0);
      check("rst_rd", 32'(bus.out_rd), 32'd0);
      check("rst_result", 32'(bus.out_result), 32'd0);
      reset = 1'b0;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // SLTI 5 < 0xFFFF, then back-to-back SLTI 0xFFFF < 0xFFFF
      drive(4'd5, 3'd3, 16'h0005, 16'h0000, 6'h3F);
      step();
      idle_in();
      check("slti_valid", 32'(bus.out_valid), 32'd1);
      check("slti_result", 32'(bus.out_result), 32'h0001);
      check("slti_rd", 32'(bus.out_rd), 32'd3);
      check("slti_we", 32'(bus.out_we), 32'd1);
      check("hold_in_ready_lo", 32'(bus.in_ready), 32'd0);
      bus.out_ready = 1'b1;
      drive(4'd5, 3'd3, 16'hFFFF, 16'h0000, 6'h3F);
      #1;
      check("hold_in_ready_hi", 32'(bus.in_ready), 32'd1);
      step();
      idle_in();
      check("slti2_valid", 32'(bus.out_valid), 32'd1);
      check("slti2_result", 32'(bus.out_result), 32'h0000);
      step();
      check("slti2_drain", 32'(bus.out_valid), 32'd0);
      check("slti2_idle", 32'(bus.busy), 32'd0);

      // three back-to-back ADDs
      drive(4'd0, 3'd1, 16'd1, 16'd2, 6'd0);
      step();
      check("add0_result", 32'(bus.out_result), 32'(add_exp[0]));
      check("add0_in_ready", 32'(bus.in_ready), 32'd1);
      drive(4'd0, 3'd2, 16'hFFFF, 16'd1, 6'd0);
      step();
      check("add1_valid", 32'(bus.out_valid), 32'd1);
      check("add1_result", 32'(bus.out_result), 32'(add_exp[1]));
      check("add1_in_ready", 32'(bus.in_ready), 32'd1);
      drive(4'd0, 3'd5, 16'd7, 16'd8, 6'd0);
      step();
      idle_in();
      check("add2_result", 32'(bus.out_result), 32'(add_exp[2]));
      check("add2_rd", 32'(bus.out_rd), 32'd5);
      step();
      check("add_drain", 32'(bus.out_valid), 32'd0);

      // backpressure for 4 cycles
      bus.out_ready = 1'b0;
      drive(4'd0, 3'd2, 16'd10, 16'd20, 6'd0);
      step();
      idle_in();
      for (int i = 0; i < 4; i++) begin
         check("bp_valid", 32'(bus.out_valid), 32'd1);
         check("bp_result", 32'(bus.out_result), 32'h001E);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         if (i < 3) step();
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(bus.in_ready), 32'd1);
      step();
      check("bp_drain", 32'(bus.out_valid), 32'd0);
      check("bp_idle", 32'(bus.busy), 32'd0);

      // SLL by 4 (upper rt bits ignored)
      drive(4'd7, 3'd4, 16'h0001, 16'hFFF4, 6'd0);
      step();
      idle_in();
      for (int i = 1; i <= 4; i++) begin
         check("sll_busy", 32'(bus.busy), 32'd1);
         check("sll_in_ready", 32'(bus.in_ready), 32'd0);
         check("sll_valid_lo", 32'(bus.out_valid), 32'd0);
         step();
      end
      check("sll_valid", 32'(bus.out_valid), 32'd1);
      check("sll_result", 32'(bus.out_result), 32'h0010);
      check("sll_rd", 32'(bus.out_rd), 32'd4);
      step();
      check("sll_drain", 32'(bus.out_valid), 32'd0);

      // SRL by 0
      drive(4'd8, 3'd1, 16'h8000, 16'h0000, 6'd0);
      step();
      idle_in();
      check("srl0_valid", 32'(bus.out_valid), 32'd1);
      check("srl0_result", 32'(bus.out_result), 32'h8000);
      step();

      // SRL by 15: 16-cycle latency
      drive(4'd8, 3'd2, 16'h8000, 16'h000F, 6'd0);
      step();
      idle_in();
      n = 1;
      while (!bus.out_valid && n < 40) begin
         step();
         n++;
      end
      check("srl15_latency", 32'(n), 32'd16);
      check("srl15_result", 32'(bus.out_result), 32'h0001);
      step();

      // reset during 2nd cycle of SLL by 10
      drive(4'd7, 3'd6, 16'h0001, 16'h000A, 6'd0);
      step();
      idle_in();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_result", 32'(bus.out_result), 32'd0);
      check("mid_rst_rd", 32'(bus.out_rd), 32'd0);
      check("mid_rst_we", 32'(bus.out_we), 32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.out_valid) n++;
      end
      check("mid_rst_no_pulse", 32'(n), 32'd0);
      drive(4'd1, 3'd6, 16'd5, 16'd7, 6'd0);
      step();
      idle_in();
      check("sub_result", 32'(bus.out_result), 32'hFFFE);
      check("sub_rd", 32'(bus.out_rd), 32'd6);
      step();

      // NOP then back-to-back SLT equal operands
      drive(4'd12, 3'd4, 16'd9, 16'd9, 6'h01);
      step();
      check("nop_valid", 32'(bus.out_valid), 32'd1);
      check("nop_we", 32'(bus.out_we), 32'd0);
      check("nop_result", 32'(bus.out_result), 32'd0);
      drive(4'd4, 3'd7, 16'd3, 16'd3, 6'd0);
      step();
      idle_in();
      check("slt_result", 32'(bus.out_result), 32'd0);
      check("slt_we", 32'(bus.out_we), 32'd1);
      check("slt_rd", 32'(bus.out_rd), 32'd7);
      step();
      check("slt_drain", 32'(bus.out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
